// File: rtl/tlul_host_arb.sv
// Two-host TL-UL arbiter: shares one device port between the instruction (host 0)
// and data (host 1) adapters with grant locking, source tagging and outstanding limits.

package tlul_host_arb_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arb
    import tlul_host_arb_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned TagBit         = 7,
    parameter logic        Host0Prio      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  tl_h2d_t    tl_h0_i,
    output tl_d2h_t    tl_h0_o,
    input  tl_h2d_t    tl_h1_i,
    output tl_d2h_t    tl_h1_o,
    output tl_h2d_t    tl_dev_o,
    input  tl_d2h_t    tl_dev_i,
    output logic [2:0] cnt_h0_o,
    output logic [2:0] cnt_h1_o,
    output logic       err_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_H0 = 2'd1,
        ST_LOCK_H1 = 2'd2
    } arb_state_e;

    localparam logic [2:0] MaxCnt = 3'(MaxOutstanding);

    arb_state_e state_r, state_next_s;
    logic       rr_r, rr_next_s;
    logic [2:0] cnt_h0_r, cnt_h1_r;
    logic       err_r;

    logic       elig_h0_s, elig_h1_s;
    logic       gnt_valid_s, gnt_host_s;
    tl_h2d_t    gnt_req_s;
    tl_d2h_t    d_rsp_s;
    logic       a_hs_s, d_dst_s, d_hs_s;
    logic       inc_h0_s, inc_h1_s, dec_h0_s, dec_h1_s;
    logic       orphan_s, tag_err_s;

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [2:0] cnt_update(input logic [2:0] cur,
                                              input logic       inc,
                                              input logic       dec);
        logic [2:0] nxt;
        case ({inc, dec})
            2'b10:   nxt = (cur < MaxCnt) ? cur + 3'd1 : cur;
            2'b01:   nxt = (cur != 3'd0) ? cur - 3'd1 : cur;
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Grant selection: a locked grant wins outright, otherwise rr/priority among eligible hosts.
    always_comb begin
        elig_h0_s   = tl_h0_i.a_valid && (cnt_h0_r < MaxCnt);
        elig_h1_s   = tl_h1_i.a_valid && (cnt_h1_r < MaxCnt);
        gnt_valid_s = 1'b0;
        gnt_host_s  = 1'b0;
        if (rst_i) begin
            gnt_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (elig_h0_s && elig_h1_s) begin
                        gnt_valid_s = 1'b1;
                        gnt_host_s  = Host0Prio ? 1'b0 : rr_r;
                    end else if (elig_h0_s) begin
                        gnt_valid_s = 1'b1;
                        gnt_host_s  = 1'b0;
                    end else if (elig_h1_s) begin
                        gnt_valid_s = 1'b1;
                        gnt_host_s  = 1'b1;
                    end else begin
                        gnt_valid_s = 1'b0;
                    end
                end
                ST_LOCK_H0: begin
                    gnt_valid_s = 1'b1;
                    gnt_host_s  = 1'b0;
                end
                ST_LOCK_H1: begin
                    gnt_valid_s = 1'b1;
                    gnt_host_s  = 1'b1;
                end
                default: gnt_valid_s = 1'b0;
            endcase
        end
    end

    assign gnt_req_s = gnt_host_s ? tl_h1_i : tl_h0_i;
    assign a_hs_s    = gnt_valid_s && gnt_req_s.a_valid && tl_dev_i.a_ready;
    assign d_dst_s   = tl_dev_i.d_source[TagBit];
    assign d_hs_s    = !rst_i && tl_dev_i.d_valid &&
                       (d_dst_s ? tl_h1_i.d_ready : tl_h0_i.d_ready);

    // Next arbiter state: hold an issued-but-unaccepted request until its handshake.
    always_comb begin
        state_next_s = state_r;
        rr_next_s    = rr_r;
        if (a_hs_s) begin
            state_next_s = ST_IDLE;
            rr_next_s    = ~gnt_host_s;
        end else if (gnt_valid_s && gnt_req_s.a_valid) begin
            state_next_s = gnt_host_s ? ST_LOCK_H1 : ST_LOCK_H0;
        end else begin
            state_next_s = state_r;
        end
    end

    // Device-side request mux with the host index stamped into the source tag.
    always_comb begin
        tl_dev_o = '0;
        if (gnt_valid_s) begin
            tl_dev_o                  = gnt_req_s;
            tl_dev_o.a_source[TagBit] = gnt_host_s;
        end else begin
            tl_dev_o = '0;
        end
        tl_dev_o.d_ready = !rst_i && (d_dst_s ? tl_h1_i.d_ready : tl_h0_i.d_ready);
    end

    // Response routing by tag bit plus per-host A-channel ready.
    always_comb begin
        tl_h0_o                  = '0;
        tl_h1_o                  = '0;
        d_rsp_s                  = tl_dev_i;
        d_rsp_s.d_source[TagBit] = 1'b0;
        d_rsp_s.d_valid          = tl_dev_i.d_valid && !rst_i;
        d_rsp_s.a_ready          = 1'b0;
        if (d_dst_s) begin
            tl_h1_o = d_rsp_s;
        end else begin
            tl_h0_o = d_rsp_s;
        end
        tl_h0_o.a_ready = gnt_valid_s && !gnt_host_s && tl_dev_i.a_ready;
        tl_h1_o.a_ready = gnt_valid_s &&  gnt_host_s && tl_dev_i.a_ready;
    end

    assign inc_h0_s  = a_hs_s && !gnt_host_s;
    assign inc_h1_s  = a_hs_s &&  gnt_host_s;
    assign dec_h0_s  = d_hs_s && !d_dst_s;
    assign dec_h1_s  = d_hs_s &&  d_dst_s;
    assign orphan_s  = (dec_h0_s && (cnt_h0_r == 3'd0)) || (dec_h1_s && (cnt_h1_r == 3'd0));
    assign tag_err_s = (tl_h0_i.a_valid && tl_h0_i.a_source[TagBit]) ||
                       (tl_h1_i.a_valid && tl_h1_i.a_source[TagBit]);

    // Arbiter state, round-robin pointer, outstanding counters and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            rr_r     <= 1'b0;
            cnt_h0_r <= 3'd0;
            cnt_h1_r <= 3'd0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            rr_r     <= rr_next_s;
            cnt_h0_r <= cnt_update(cnt_h0_r, inc_h0_s, dec_h0_s);
            cnt_h1_r <= cnt_update(cnt_h1_r, inc_h1_s, dec_h1_s);
            err_r    <= err_r | orphan_s | tag_err_s;
        end
    end

    assign cnt_h0_o = cnt_h0_r;
    assign cnt_h1_o = cnt_h1_r;
    assign err_o    = err_r;

endmodule

// File: tb/tb_tlul_host_arb.sv
// Scoreboard bench for tlul_host_arb: directed stimulus pushes expected A/D beats,
// a negedge monitor pops and compares whenever a handshake appears.

module tb_tlul_host_arb;
    import tlul_host_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_i;
    tl_h2d_t    h0_req, h1_req, dev_req, dev2_req;
    tl_d2h_t    h0_rsp, h1_rsp, dev_rsp, h0_rsp2, h1_rsp2;
    logic [2:0] cnt0, cnt1, cnt0_2, cnt1_2;
    logic       err, err2;
    logic       acc0, acc1;

    typedef struct { logic [31:0] addr; logic [7:0] src; } a_exp_t;
    typedef struct { logic [7:0] src; logic [31:0] data; } d_exp_t;
    a_exp_t a_q[$];
    d_exp_t d_q0[$];
    d_exp_t d_q1[$];

    int checks   = 0;
    int failures = 0;

    tlul_host_arb dut (
        .clk_i(clk), .rst_i(rst_i),
        .tl_h0_i(h0_req), .tl_h0_o(h0_rsp),
        .tl_h1_i(h1_req), .tl_h1_o(h1_rsp),
        .tl_dev_o(dev_req), .tl_dev_i(dev_rsp),
        .cnt_h0_o(cnt0), .cnt_h1_o(cnt1), .err_o(err)
    );

    tlul_host_arb #(.MaxOutstanding(7), .TagBit(7), .Host0Prio(1'b1)) dut_prio (
        .clk_i(clk), .rst_i(rst_i),
        .tl_h0_i(h0_req), .tl_h0_o(h0_rsp2),
        .tl_h1_i(h1_req), .tl_h1_o(h1_rsp2),
        .tl_dev_o(dev2_req), .tl_dev_i(dev_rsp),
        .cnt_h0_o(cnt0_2), .cnt_h1_o(cnt1_2), .err_o(err2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] addr, input logic [7:0] src);
        a_exp_t e;
        e.addr = addr;
        e.src  = src;
        a_q.push_back(e);
    endtask

    task automatic d_drive(input logic [7:0] src, input logic [31:0] data);
        d_exp_t e;
        e.src  = {1'b0, src[6:0]};
        e.data = data;
        if (src[7]) d_q1.push_back(e);
        else        d_q0.push_back(e);
        dev_rsp.d_valid  = 1'b1;
        dev_rsp.d_source = src;
        dev_rsp.d_data   = data;
    endtask

    task automatic send_d(input logic [7:0] src, input logic [31:0] data);
        d_drive(src, data);
        cyc();
        dev_rsp.d_valid = 1'b0;
    endtask

    // Monitor: compare every observed A/D handshake against the scoreboard queues.
    always @(negedge clk) begin : monitor
        a_exp_t ea;
        d_exp_t ed;
        if (dev_req.a_valid && dev_rsp.a_ready) begin
            if (a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: addr 0x%0h src 0x%0h with empty queue", dev_req.a_address, dev_req.a_source);
            end else begin
                ea = a_q.pop_front();
                chk("a_addr", dev_req.a_address, ea.addr);
                chk("a_src", 32'(dev_req.a_source), 32'(ea.src));
            end
        end
        if (h0_rsp.d_valid && h0_req.d_ready) begin
            if (d_q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d0_unexpected: src 0x%0h with empty queue", h0_rsp.d_source);
            end else begin
                ed = d_q0.pop_front();
                chk("d0_src", 32'(h0_rsp.d_source), 32'(ed.src));
                chk("d0_data", h0_rsp.d_data, ed.data);
            end
        end
        if (h1_rsp.d_valid && h1_req.d_ready) begin
            if (d_q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d1_unexpected: src 0x%0h with empty queue", h1_rsp.d_source);
            end else begin
                ed = d_q1.pop_front();
                chk("d1_src", 32'(h1_rsp.d_source), 32'(ed.src));
                chk("d1_data", h1_rsp.d_data, ed.data);
            end
        end
    end

    initial begin
        h0_req = '0;
        h1_req = '0;
        h0_req.d_ready = 1'b1;
        h1_req.d_ready = 1'b1;
        dev_rsp = '0;
        rst_i = 1'b1;

        // Reset: a pending request must not leak through
        dev_rsp.a_ready  = 1'b1;
        h0_req.a_valid   = 1'b1;
        h0_req.a_address = 32'h0000_0050;
        @(negedge clk);
        chk("rst_dev_a_valid", 32'(dev_req.a_valid), 32'd0);
        chk("rst_h0_a_ready", 32'(h0_rsp.a_ready), 32'd0);
        cyc();
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_cnt1", 32'(cnt1), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        h0_req.a_valid = 1'b0;
        rst_i = 1'b0;

        // Single host read
        h1_req.a_valid   = 1'b1;
        h1_req.a_opcode  = 3'd4;
        h1_req.a_address = 32'h0000_0100;
        h1_req.a_source  = 8'h01;
        push_a(32'h0000_0100, 8'h81);
        cyc();
        h1_req.a_valid = 1'b0;
        chk("single_cnt1_inc", 32'(cnt1), 32'd1);
        cyc();
        cyc();
        chk("single_cnt1_hold", 32'(cnt1), 32'd1);
        send_d(8'h81, 32'hDEAD_BEEF);
        chk("single_cnt1_dec", 32'(cnt1), 32'd0);

        // Round-robin contention
        h0_req.a_valid = 1'b1; h0_req.a_address = 32'h0000_0200; h0_req.a_source = 8'h05;
        h1_req.a_valid = 1'b1; h1_req.a_address = 32'h0000_0300; h1_req.a_source = 8'h06;
        push_a(32'h0000_0200, 8'h05);
        push_a(32'h0000_0300, 8'h86);
        push_a(32'h0000_0204, 8'h05);
        push_a(32'h0000_0304, 8'h86);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc0 = h0_rsp.a_ready;
            acc1 = h1_rsp.a_ready;
            chk("prio_h0_grant", 32'(dev2_req.a_valid && !dev2_req.a_source[7]), 32'd1);
            cyc();
            if (acc0) h0_req.a_address = h0_req.a_address + 32'd4;
            if (acc1) h1_req.a_address = h1_req.a_address + 32'd4;
        end
        h0_req.a_valid = 1'b0;
        h1_req.a_valid = 1'b0;
        chk("rr_cnt0", 32'(cnt0), 32'd2);
        chk("rr_cnt1", 32'(cnt1), 32'd2);
        send_d(8'h05, 32'h0000_A200);
        send_d(8'h05, 32'h0000_A204);
        send_d(8'h86, 32'h0000_A300);
        send_d(8'h86, 32'h0000_A304);
        chk("rr_drain_cnt0", 32'(cnt0), 32'd0);
        chk("rr_drain_cnt1", 32'(cnt1), 32'd0);

        // Grant lock while device stalls
        dev_rsp.a_ready = 1'b0;
        h0_req.a_valid = 1'b1; h0_req.a_address = 32'h0000_0400; h0_req.a_source = 8'h05;
        h1_req.a_valid = 1'b1; h1_req.a_address = 32'h0000_0500; h1_req.a_source = 8'h06;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lock_valid", 32'(dev_req.a_valid), 32'd1);
            chk("lock_addr", dev_req.a_address, 32'h0000_0400);
            chk("lock_h1_ready", 32'(h1_rsp.a_ready), 32'd0);
            cyc();
        end
        push_a(32'h0000_0400, 8'h05);
        push_a(32'h0000_0500, 8'h86);
        dev_rsp.a_ready = 1'b1;
        @(negedge clk);
        chk("lock_release_h1_wait", 32'(h1_rsp.a_ready), 32'd0);
        cyc();
        h0_req.a_valid = 1'b0;
        @(negedge clk);
        chk("lock_h1_next", 32'(h1_rsp.a_ready), 32'd1);
        cyc();
        h1_req.a_valid = 1'b0;
        send_d(8'h05, 32'h0000_B400);
        send_d(8'h86, 32'h0000_B500);

        // Outstanding limit on host 0
        h0_req.a_valid = 1'b1; h0_req.a_address = 32'h0000_0600;
        push_a(32'h0000_0600, 8'h05);
        cyc();
        h0_req.a_address = 32'h0000_0604;
        push_a(32'h0000_0604, 8'h05);
        cyc();
        chk("lim_cnt0_full", 32'(cnt0), 32'd2);
        h0_req.a_address = 32'h0000_0608;
        h1_req.a_valid = 1'b1; h1_req.a_address = 32'h0000_0700;
        push_a(32'h0000_0700, 8'h86);
        @(negedge clk);
        chk("lim_h0_blocked", 32'(h0_rsp.a_ready), 32'd0);
        cyc();
        h1_req.a_valid = 1'b0;
        d_drive(8'h05, 32'h0000_C600);
        @(negedge clk);
        chk("lim_h0_same_cycle", 32'(h0_rsp.a_ready), 32'd0);
        cyc();
        dev_rsp.d_valid = 1'b0;
        push_a(32'h0000_0608, 8'h05);
        @(negedge clk);
        chk("lim_h0_next", 32'(h0_rsp.a_ready), 32'd1);
        cyc();
        h0_req.a_valid = 1'b0;
        chk("lim_cnt0", 32'(cnt0), 32'd2);
        chk("lim_cnt1", 32'(cnt1), 32'd1);
        send_d(8'h05, 32'h0000_C604);
        send_d(8'h05, 32'h0000_C608);
        send_d(8'h86, 32'h0000_C700);
        chk("lim_drain_cnt0", 32'(cnt0), 32'd0);
        chk("lim_drain_cnt1", 32'(cnt1), 32'd0);

        // Orphan response and tag misuse
        chk("err_clear", 32'(err), 32'd0);
        send_d(8'h80, 32'h0000_BAD0);
        chk("orphan_err", 32'(err), 32'd1);
        chk("orphan_cnt1", 32'(cnt1), 32'd0);
        cyc();
        chk("orphan_sticky", 32'(err), 32'd1);
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        chk("err_after_rst", 32'(err), 32'd0);
        h0_req.a_valid = 1'b1; h0_req.a_address = 32'h0000_0800; h0_req.a_source = 8'h80;
        push_a(32'h0000_0800, 8'h00);
        cyc();
        h0_req.a_valid = 1'b0;
        h0_req.a_source = 8'h05;
        chk("tag_err", 32'(err), 32'd1);
        chk("tag_cnt0", 32'(cnt0), 32'd1);

        // Reset while locked on host 1 with host 0 full
        rst_i = 1'b1;
        cyc();
        rst_i = 1'b0;
        h0_req.a_valid = 1'b1; h0_req.a_address = 32'h0000_0900;
        push_a(32'h0000_0900, 8'h05);
        cyc();
        h0_req.a_address = 32'h0000_0904;
        push_a(32'h0000_0904, 8'h05);
        cyc();
        dev_rsp.a_ready = 1'b0;
        h0_req.a_address = 32'h0000_0908;
        h1_req.a_valid = 1'b1; h1_req.a_address = 32'h0000_0A00;
        @(negedge clk);
        chk("pre_rst_lock_src", 32'(dev_req.a_source), 32'h86);
        cyc();
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_dev_valid", 32'(dev_req.a_valid), 32'd0);
        cyc();
        rst_i = 1'b0;
        chk("rst_mid_cnt0", 32'(cnt0), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        dev_rsp.a_ready = 1'b1;
        push_a(32'h0000_0908, 8'h05);
        @(negedge clk);
        chk("post_rst_h0_ready", 32'(h0_rsp.a_ready), 32'd1);
        chk("post_rst_h1_ready", 32'(h1_rsp.a_ready), 32'd0);
        cyc();
        h0_req.a_valid = 1'b0;
        h1_req.a_valid = 1'b0;
        send_d(8'h86, 32'h0000_DA00);
        chk("post_rst_orphan_err", 32'(err), 32'd1);

        repeat (3) cyc();
        chk("a_queue_empty", 32'(a_q.size()), 32'd0);
        chk("d0_queue_empty", 32'(d_q0.size()), 32'd0);
        chk("d1_queue_empty", 32'(d_q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
